// File: rtl/fifo_pkg.sv
// Shared constants and types for the 512x32 synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_DEPTH  = 512;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
  typedef logic [FIFO_ADDR_W-1:0] fifo_ptr_t;
  typedef logic [FIFO_ADDR_W:0]   fifo_cnt_t;

  // Pointer advance; wraps naturally because the pointer is exactly log2(depth) bits.
  function automatic fifo_ptr_t fifo_ptr_inc(input fifo_ptr_t p);
    return fifo_ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/sdp_ram_512x32.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module sdp_ram_512x32
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; output holds when no read is requested.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_32x512.sv
// Single-clock standard-mode FIFO, 512 x 32, with overflow/underflow pulses.
// Optional build macro SYNC_FIFO_DATA_COUNT_EN exposes the occupancy as data_count.
module sync_fifo_32x512
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [DATA_W-1:0]          din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
`ifdef SYNC_FIFO_DATA_COUNT_EN
  output logic [$clog2(DEPTH):0]     data_count,
`endif
  output logic                       underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic              overflow_q, underflow_q;
  logic              dout_vld_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // Request qualification; reset cycle ignores both requests.
  always_comb begin
    wr_acc = wr_en & ~full_q  & ~srst;
    rd_acc = rd_en & ~empty_q & ~srst;
  end

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers, occupancy, flags and error pulses.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_vld_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CNT_FULL);
      empty_q     <= (count_d == '0);
      overflow_q  <= wr_en & full_q;
      underflow_q <= rd_en & empty_q;
      if (rd_acc) begin
        dout_vld_q <= 1'b1;
      end
    end
  end

  sdp_ram_512x32 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset (block RAM friendly), so dout reads
  // as zero until the first read after reset has loaded it.
  always_comb begin
    dout = dout_vld_q ? ram_rdata : '0;
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`ifdef SYNC_FIFO_DATA_COUNT_EN
  assign data_count = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_32x512.sv
// Directed self-checking bench for sync_fifo_32x512.
module tb_sync_fifo_32x512;

  logic        clk;
  logic        srst;
  logic [31:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;
`ifdef SYNC_FIFO_DATA_COUNT_EN
  logic [9:0]  data_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_32x512 dut (
    .clk        (clk),
    .srst       (srst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
`ifdef SYNC_FIFO_DATA_COUNT_EN
    .data_count (data_count),
`endif
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst  = 1'b1;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    step();
    step();
    srst = 1'b0;
    step();

    // Reset / idle state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_dout",  dout, 32'h0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_unf",   32'(underflow), 32'd0);

    // Three writes, three reads
    wr_en = 1'b1;
    din = 32'h1; step();
    check("w1_empty", 32'(empty), 32'd0);
    din = 32'h2; step();
    din = 32'h3; step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step(); check("rd1", dout, 32'h1);
    step(); check("rd2", dout, 32'h2);
    step(); check("rd3", dout, 32'h3);
    rd_en = 1'b0;
    check("rd3_empty", 32'(empty), 32'd1);
    check("rd3_unf", 32'(underflow), 32'd0);
    step();
    check("idle_dout_hold", dout, 32'h3);

    // Fill to full (write pointer wraps past 0 during this)
    wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      din = 32'hA500_0000 + 32'(i);
      step();
      if (i == 510) check("fill511_full", 32'(full), 32'd0);
    end
    check("fill512_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_DATA_COUNT_EN
    check("cnt512", 32'(data_count), 32'd512);
`endif
    din = 32'hBAD0_0001; step();
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_full", 32'(full), 32'd1);
    wr_en = 1'b0;
    step();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full with simultaneous read and write: write dropped
    wr_en = 1'b1; rd_en = 1'b1; din = 32'hBAD0_0002;
    step();
    check("fullrw_dout", dout, 32'hA500_0000);
    check("fullrw_full", 32'(full), 32'd0);
    check("fullrw_ovf", 32'(overflow), 32'd1);
`ifdef SYNC_FIFO_DATA_COUNT_EN
    check("cnt511", 32'(data_count), 32'd511);
`endif
    wr_en = 1'b0;
    for (int i = 1; i < 512; i++) begin
      step();
      check("drain", dout, 32'hA500_0000 + 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Empty with simultaneous read and write
    wr_en = 1'b1; rd_en = 1'b1; din = 32'hDEAD_BEEF;
    step();
    check("emptyrw_unf", 32'(underflow), 32'd1);
    check("emptyrw_empty", 32'(empty), 32'd0);
    check("emptyrw_dout", dout, 32'hA500_01FF);
    wr_en = 1'b0;
    step();
    check("emptyrw_next", dout, 32'hDEAD_BEEF);
    check("emptyrw_empty2", 32'(empty), 32'd1);
    check("emptyrw_unf_clr", 32'(underflow), 32'd0);
    rd_en = 1'b0;

    // Mid-operation reset with 100 words stored
    wr_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 32'h5500_0000 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_full", 32'(full), 32'd0);
    check("mrst_dout", dout, 32'h0);
`ifdef SYNC_FIFO_DATA_COUNT_EN
    check("mrst_cnt", 32'(data_count), 32'd0);
`endif
    wr_en = 1'b1; din = 32'h1234_5678;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    check("mrst_rd", dout, 32'h1234_5678);
    check("mrst_rd_empty", 32'(empty), 32'd1);
    step();
    check("mrst_stale_unf", 32'(underflow), 32'd1);
    check("mrst_stale_dout", dout, 32'h1234_5678);
    rd_en = 1'b0;
    step();
    check("mrst_unf_clr", 32'(underflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
